// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: controller state encoding,
// default depth and word-index width derivation.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (see mem_responder.sv).
package mem_pkg;

    localparam int MEM_DEPTH_DEFAULT = 512;
    localparam int MEM_WORD_BITS     = 32;

    // Controller states, kept as plain encoded constants so older blocks
    // that compare against raw 2-bit codes keep working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    // Width of the word index into an array of 'depth' words (at least 1).
    function automatic int calc_addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: one synchronous write port and one
// registered read port. Only the read register is reset; the stored words
// survive reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH     = MEM_DEPTH_DEFAULT,
    parameter int ADDR_BITS = calc_addr_bits(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_BITS-1:0]     wr_idx,
    input  logic [MEM_WORD_BITS-1:0] wr_data,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [ADDR_BITS-1:0]     rd_idx,
    output logic [MEM_WORD_BITS-1:0] rd_data
);

    logic [MEM_WORD_BITS-1:0] mem [DEPTH];

    // Commit a write word on the clock edge it is enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register: loads on a read, can be forced to zero, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for a simple CPU bus. A request is latched in
// IDLE, delayed by WAIT_STATES cycles, answered with a one-cycle Ready pulse,
// and then parked in HOLD until the CPU drops its request.
// Optional feature macro: MEM_BOUNDS_CHECK_EN -- flags addresses >= DEPTH
// with Err, suppresses their writes and returns zero for their reads.
// Without it addresses wrap on the low index bits and Err is always 0.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH_DEFAULT,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic        Ready,
    output logic        Err
);

    localparam int ADDR_BITS = calc_addr_bits(DEPTH);

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             cnt;
    logic                   op_write;
    logic [ADDR_BITS-1:0]   idx_r;
    logic [31:0]            data_r;
    logic                   req;
    logic                   enter_resp;
    logic                   cur_write;
    logic [ADDR_BITS-1:0]   cur_idx;
    logic                   mem_wr_en;
    logic                   mem_rd_en;
    logic                   mem_rd_clr;
    logic                   blocked;

    assign req = Read | Write;

    // In IDLE the operation is still on the bus; afterwards use the latched copy.
    assign cur_write = (state == ST_IDLE) ? Write : op_write;
    assign cur_idx   = (state == ST_IDLE) ? address[ADDR_BITS-1:0] : idx_r;

    // Next-state decode; enter_resp marks the edge that moves into RESP.
    always_comb begin
        next_state = state;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        next_state = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: next_state = ST_HOLD;
            ST_HOLD: begin
                if (!req) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, wait counter and captured request registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            idx_r    <= '0;
            data_r   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req) begin
                op_write <= Write;
                idx_r    <= address[ADDR_BITS-1:0];
                data_r   <= data;
                cnt      <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob_r;
    logic cur_oob;

    assign cur_oob = (state == ST_IDLE) ? (address >= 32'(DEPTH)) : oob_r;

    // Remember whether the accepted address lies outside the array.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            oob_r <= 1'b0;
        end else if (state == ST_IDLE && req) begin
            oob_r <= (address >= 32'(DEPTH));
        end
    end

    assign blocked    = oob_r;
    assign mem_rd_clr = enter_resp && !cur_write && cur_oob;
    assign Err        = (state == ST_RESP) && oob_r;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^address[31:ADDR_BITS];
    assign blocked        = 1'b0;
    assign mem_rd_clr     = 1'b0;
    assign Err            = 1'b0;
`endif

    assign mem_rd_en = enter_resp && !cur_write;
    assign mem_wr_en = (state == ST_RESP) && op_write && !blocked;
    assign Ready     = (state == ST_RESP);

    mem_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (Reset),
        .wr_en   (mem_wr_en),
        .wr_idx  (idx_r),
        .wr_data (data_r),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .rd_idx  (cur_idx),
        .rd_data (q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with the default two wait
// states and one with zero wait states, sharing clock and reset.
module tb_mem_responder;

    logic        clk;
    logic        reset_n;

    logic        read_a, write_a;
    logic [31:0] address_a, data_a, q_a;
    logic        ready_a, err_a;

    logic        read_z, write_z;
    logic [31:0] address_z, data_z, q_z;
    logic        ready_z, err_z;

    int num_compared;
    int num_mismatched;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    mem_responder #(.DEPTH(512), .WAIT_STATES(2)) dut (
        .clk     (clk),
        .Reset   (reset_n),
        .Read    (read_a),
        .Write   (write_a),
        .address (address_a),
        .data    (data_a),
        .q       (q_a),
        .Ready   (ready_a),
        .Err     (err_a)
    );

    mem_responder #(.DEPTH(512), .WAIT_STATES(0)) dut_zero (
        .clk     (clk),
        .Reset   (reset_n),
        .Read    (read_z),
        .Write   (write_z),
        .address (address_z),
        .data    (data_z),
        .q       (q_z),
        .Ready   (ready_z),
        .Err     (err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input bit use_zero, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (use_zero) begin
            read_z = rd; write_z = wr; address_z = addr; data_z = wdata;
        end else begin
            read_a = rd; write_a = wr; address_a = addr; data_a = wdata;
        end
    endtask

    function automatic logic readyOf(input bit use_zero);
        return use_zero ? ready_z : ready_a;
    endfunction

    // One full bus transaction: returns the Ready latency in cycles after the
    // accept edge (-1 on timeout), q and Err seen with Ready, and Ready one
    // cycle later. Address/data are scrambled after accept.
    task automatic applyStimulus(input bit use_zero, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] qv,
                                 output logic errv, output logic ready_after);
        lat = -1; qv = '0; errv = 1'b0; ready_after = 1'b0;
        @(negedge clk);
        driveReq(use_zero, rd, wr, addr, wdata);
        @(posedge clk);
        #1;
        driveReq(use_zero, rd, wr, ~addr, ~wdata);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (readyOf(use_zero)) begin
                lat  = k;
                qv   = use_zero ? q_z : q_a;
                errv = use_zero ? err_z : err_a;
                break;
            end
        end
        @(negedge clk);
        ready_after = readyOf(use_zero);
        driveReq(use_zero, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic countPulses(input bit use_zero, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (readyOf(use_zero)) n++;
        end
    endtask

    int          lat;
    logic [31:0] qv;
    logic        errv;
    logic        after;
    int          pulses;

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        reset_n = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        driveReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_q", q_a, 32'h0);
        checkOutput("reset_ready", {31'b0, ready_a}, 32'h0);
        checkOutput("reset_err", {31'b0, err_a}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Write then read at address 5
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, qv, errv, after);
        checkOutput("wr5_latency", 32'(lat), 32'd3);
        checkOutput("wr5_err", {31'b0, errv}, 32'h0);
        checkOutput("wr5_pulse_width", {31'b0, after}, 32'h0);
        checkOutput("wr5_q_unchanged", qv, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, lat, qv, errv, after);
        checkOutput("rd5_latency", 32'(lat), 32'd3);
        checkOutput("rd5_q", qv, 32'hDEADBEEF);

        // Held read request services once per assertion
        @(negedge clk);
        driveReq(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        countPulses(1'b0, 10, pulses);
        checkOutput("held_pulses_first", 32'(pulses), 32'd1);
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        countPulses(1'b0, 3, pulses);
        driveReq(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        countPulses(1'b0, 10, pulses);
        checkOutput("held_pulses_second", 32'(pulses), 32'd1);
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a write leaves the old word intact
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd7, 32'hAA, lat, qv, errv, after);
        checkOutput("wr7_latency", 32'(lat), 32'd3);
        @(negedge clk);
        driveReq(1'b0, 1'b0, 1'b1, 32'd7, 32'h55);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_ready", {31'b0, ready_a}, 32'h0);
        checkOutput("midreset_q", q_a, 32'h0);
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        countPulses(1'b0, 6, pulses);
        checkOutput("midreset_no_pulse", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, lat, qv, errv, after);
        checkOutput("rd7_latency", 32'(lat), 32'd3);
        checkOutput("rd7_q_old", qv, 32'hAA);

        // Read and Write together act as a write
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd3, 32'h77, lat, qv, errv, after);
        checkOutput("both_latency", 32'(lat), 32'd3);
        checkOutput("both_q_unchanged", qv, 32'hAA);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, lat, qv, errv, after);
        checkOutput("rd3_q", qv, 32'h77);

        // Address beyond the array: flagged or wrapped depending on build
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd88, 32'h88888888, lat, qv, errv, after);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd600, 32'h1, lat, qv, errv, after);
        checkOutput("wr600_latency", 32'(lat), 32'd3);
        checkOutput("wr600_err", {31'b0, errv}, BOUNDS ? 32'h1 : 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd88, 32'h0, lat, qv, errv, after);
        checkOutput("rd88_q", qv, BOUNDS ? 32'h88888888 : 32'h1);
        checkOutput("rd88_err", {31'b0, errv}, 32'h0);
        if (BOUNDS) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd600, 32'h0, lat, qv, errv, after);
            checkOutput("rd600_q", qv, 32'h0);
            checkOutput("rd600_err", {31'b0, errv}, 32'h1);
        end

        // Zero wait states: Ready in the first cycle after accept
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0, 32'h12, lat, qv, errv, after);
        checkOutput("z_wr0_latency", 32'(lat), 32'd1);
        checkOutput("z_wr0_pulse_width", {31'b0, after}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h0, lat, qv, errv, after);
        checkOutput("z_rd0_latency", 32'(lat), 32'd1);
        checkOutput("z_rd0_q", qv, 32'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 512, meaning the number of 32-bit words stored.
REQ-002 The module SHALL have parameter WAIT_STATES, default 2, meaning idle cycles inserted between request accept and response (0..15).
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The module SHALL have port Read, input, 1, meaning the CPU read request, held until Ready is seen.
REQ-006 The module SHALL have port Write, input, 1, meaning the CPU write request, held until Ready is seen.
REQ-007 The module SHALL have port address, input, 32, meaning the word address from MAR.
REQ-008 The module SHALL have port data, input, 32, meaning the write data from MDR.
REQ-009 The module SHALL have port q, output, 32, meaning the read data returned to the MDR mux.
REQ-010 The module SHALL have port Ready, output, 1, meaning a one-cycle completion strobe.
REQ-011 The module SHALL have port Err, output, 1, meaning an access fault, valid only while Ready is high.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, RESP and HOLD.
REQ-013 In IDLE, the module SHALL accept a request when Read or Write is high, latching address, data and the operation into internal registers.
REQ-014 If Read and Write are both high at accept, the module SHALL treat the request as a write.
REQ-015 On accept, the FSM SHALL go to WAIT with a counter loaded to WAIT_STATES; with WAIT_STATES=0 it SHALL go directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the cycle after the counter reaches 1.
REQ-017 In RESP, Ready SHALL be high for exactly one cycle.
REQ-018 In RESP, for a write, the array word SHALL be updated on the RESP clock edge.
REQ-019 In RESP, for a read, q SHALL hold the addressed word while Ready is high.
REQ-020 Latency from the accept edge to Ready high SHALL be WAIT_STATES+1 cycles.
REQ-021 After RESP, the FSM SHALL enter HOLD and remain there until Read and Write are both low, then return to IDLE; a held request SHALL never be serviced twice.
REQ-022 q SHALL retain the last read value until the next read completes; writes SHALL NOT change q.
REQ-023 Changes to address, data, Read or Write after accept SHALL NOT affect the in-flight operation.
REQ-024 The word index SHALL be address[ADDR_BITS-1:0], where ADDR_BITS = clog2(DEPTH).

Reset
REQ-025 Asserting Reset low SHALL immediately force IDLE, q=0, Ready=0, Err=0 and counter=0.
REQ-026 A reset during WAIT or RESP SHALL abort the operation; a write not yet committed SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 When MEM_BOUNDS_CHECK_EN is defined, an access with address >= DEPTH SHALL complete normally in timing with Err=1 during Ready, writes SHALL be suppressed, and reads SHALL return q=0.
REQ-029 When MEM_BOUNDS_CHECK_EN is undefined, addresses SHALL wrap modulo DEPTH and Err SHALL be tied to 0.

Structure
REQ-030 Package mem_pkg SHALL hold the FSM state enum, the DEPTH default and the ADDR_BITS derivation.
REQ-031 Storage SHALL be a sub-module mem_array with a synchronous write port and a registered read port; the FSM, counter and bounds check SHALL reside in mem_responder.

Verification
REQ-032 Write-then-read scenario: write data 0xDEADBEEF to address 5, then read address 5 -> Ready 3 cycles after each accept, and q=0xDEADBEEF.
REQ-033 Zero-latency scenario: with WAIT_STATES=0, read address 0 (preloaded 0x12) -> Ready on the cycle after accept with q=0x12.
REQ-034 Held-request scenario: hold Read high for 10 cycles -> exactly one Ready pulse; release Read and reassert it -> a second pulse.
REQ-035 Reset-mid-write scenario: write 0x55 to address 7 (old value 0xAA) and pull Reset low during WAIT -> Ready never pulses, and a later read returns 0xAA.
REQ-036 Bounds scenario: with MEM_BOUNDS_CHECK_EN, write 0x1 to address 600 -> Ready=1 and Err=1, address 600 mod 512 = 88 unchanged. Without the macro, the same write lands at word 88 with Err=0.
REQ-037 Simultaneous-request scenario: raise Read and Write together with data 0x77 at address 3 -> treated as a write, and a later read returns 0x77.
